// File: rtl/qconv2d_core_if.sv
// Bundle for the qconv2d core: pixel/weight/bias inputs with their valid strobe,
// and the registered result bus with its valid flag.
interface qconv2d_core_if #(
   parameter int XN = 64,
   parameter int KN = 72,
   parameter int BN = 8,
   parameter int YN = 128,
   parameter int XB = 11,
   parameter int KB = 6,
   parameter int YB = XB + KB + $clog2(10)
);
   logic                  in_valid;
   logic [XN-1:0][XB-1:0] x;
   logic [KN-1:0][KB-1:0] k;
   logic [BN-1:0][KB-1:0] b;
   logic [YN-1:0][YB-1:0] y;
   logic                  out_valid;

   modport master (output in_valid, x, k, b, input  y, out_valid);
   modport slave  (input  in_valid, x, k, b, output y, out_valid);
endinterface

// File: rtl/qconv2d_core.sv
// Quantised 3x3 stride-2 convolution of an 8x8 single-channel image into 4x4x8 outputs.
// The whole MAC array is combinational; only the result and its valid flag are registered.
module qconv2d_core #(
   parameter int XN = 64,
   parameter int KN = 72,
   parameter int BN = 8,
   parameter int YN = 128,
   parameter int XB = 11,
   parameter int KB = 6,
   parameter int YB = XB + KB + $clog2(10)
) (
   input  logic          clk,
   input  logic          rstn,
   qconv2d_core_if.slave bus
);
   localparam int CO = BN;
   localparam int IW = 8;
   localparam int IH = XN / IW;
   localparam int KW = 3;
   localparam int KH = KN / (KW * CO);
   localparam int OW = (IW + 1) / 2;
   localparam int OH = (IH + 1) / 2;

   logic [YN-1:0][YB-1:0] y_d;
   logic [YN-1:0][YB-1:0] y_q;
   logic                  valid_q;

   for (genvar oh = 0; oh < OH; oh++) begin : gOh
      for (genvar ow = 0; ow < OW; ow++) begin : gOw
         for (genvar co = 0; co < CO; co++) begin : gCo
            logic signed [YB-1:0] bias;
            assign bias = YB'($signed(bus.b[co][KB-1:0]));

            for (genvar kr = 0; kr < KH; kr++) begin : gKr
               for (genvar kc = 0; kc < KW; kc++) begin : gKc
                  localparam int R = 2 * oh + kr;
                  localparam int C = 2 * ow + kc;
                  localparam int T = kr * KW + kc;
                  logic signed [YB-1:0] prod;

                  // Taps falling on row/column 8 are the bottom/right zero padding.
                  if (R < IH && C < IW) begin : gTap
                     assign prod = YB'($signed(bus.x[R*IW+C][XB-1:0]))
                                 * YB'($signed(bus.k[T*CO+co][KB-1:0]));
                  end else begin : gPad
                     assign prod = '0;
                  end
               end
            end

            assign y_d[(oh*OW+ow)*CO+co] = bias
               + gKr[0].gKc[0].prod + gKr[0].gKc[1].prod + gKr[0].gKc[2].prod
               + gKr[1].gKc[0].prod + gKr[1].gKc[1].prod + gKr[1].gKc[2].prod
               + gKr[2].gKc[0].prod + gKr[2].gKc[1].prod + gKr[2].gKc[2].prod;
         end
      end
   end

   // Result register loads only on valid cycles and otherwise holds.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            y_q <= y_d;
         end
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_qconv2d_core.sv
// Self-checking bench for qconv2d_core: directed uniform-fill table, hand sequences
// for reset/throughput/hold, and a random regression against an integer reference.
module tb_qconv2d_core;
   localparam int XN = 64;
   localparam int KN = 72;
   localparam int BN = 8;
   localparam int YN = 128;
   localparam int XB = 11;
   localparam int KB = 6;
   localparam int YB = 21;

   typedef logic [XN-1:0][XB-1:0] xArr_t;
   typedef logic [KN-1:0][KB-1:0] kArr_t;
   typedef logic [BN-1:0][KB-1:0] bArr_t;
   typedef logic [YN-1:0][YB-1:0] yArr_t;

   typedef struct packed {
      bit [95:0] name;
      int        xVal;
      int        kVal;
      int        bVal;
      int        expInterior;
      int        expEdge;
      int        expCorner;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   qconv2d_core_if bus ();

   qconv2d_core u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   function automatic yArr_t refModel(input xArr_t xv, input kArr_t kv, input bArr_t bv);
      yArr_t yv;
      yv = '0;
      for (int oh = 0; oh < 4; oh++) begin
         for (int ow = 0; ow < 4; ow++) begin
            for (int co = 0; co < 8; co++) begin
               int acc;
               acc = int'($signed(bv[co]));
               for (int kr = 0; kr < 3; kr++) begin
                  for (int kc = 0; kc < 3; kc++) begin
                     int r;
                     int c;
                     r = 2 * oh + kr;
                     c = 2 * ow + kc;
                     if (r <= 7 && c <= 7) begin
                        acc = acc + int'($signed(xv[r*8+c])) * int'($signed(kv[(kr*3+kc)*8+co]));
                     end
                  end
               end
               yv[(oh*4+ow)*8+co] = YB'(acc);
            end
         end
      end
      return yv;
   endfunction

   function automatic yArr_t uniformExpect(input int eInt, input int eEdge, input int eCorner);
      yArr_t yv;
      for (int oh = 0; oh < 4; oh++) begin
         for (int ow = 0; ow < 4; ow++) begin
            for (int co = 0; co < 8; co++) begin
               if (oh < 3 && ow < 3) yv[(oh*4+ow)*8+co] = YB'(eInt);
               else if (oh == 3 && ow == 3) yv[(oh*4+ow)*8+co] = YB'(eCorner);
               else yv[(oh*4+ow)*8+co] = YB'(eEdge);
            end
         end
      end
      return yv;
   endfunction

   task automatic randVec(output xArr_t xv, output kArr_t kv, output bArr_t bv);
      for (int i = 0; i < XN; i++) xv[i] = XB'($urandom);
      for (int i = 0; i < KN; i++) kv[i] = KB'($urandom);
      for (int i = 0; i < BN; i++) bv[i] = KB'($urandom);
   endtask

   task automatic applyStimulus(input logic v, input xArr_t xv, input kArr_t kv, input bArr_t bv);
      bus.in_valid = v;
      bus.x        = xv;
      bus.k        = kv;
      bus.b        = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic expValid, input yArr_t expY);
      int bad;
      checks++;
      if (bus.out_valid !== expValid) begin
         errors++;
         $display("[TB] FAIL %s out_valid: got %0b want %0b", name, bus.out_valid, expValid);
      end
      checks++;
      bad = -1;
      for (int i = YN - 1; i >= 0; i--) begin
         if (bus.y[i] !== expY[i]) bad = i;
      end
      if (bad >= 0) begin
         errors++;
         $display("[TB] FAIL %s y[%0d]: got %0d want %0d", name, bad,
                  $signed(bus.y[bad]), $signed(expY[bad]));
      end
   endtask

   initial begin
      vec_t  vecs [4];
      xArr_t xv, xv2;
      kArr_t kv, kv2;
      bArr_t bv, bv2;
      yArr_t ev, ev2;

      vecs[0] = '{name: "all_ones", xVal: 1,     kVal: 1,   bVal: 0,   expInterior: 9,      expEdge: 6,      expCorner: 4};
      vecs[1] = '{name: "extremes", xVal: -1024, kVal: -32, bVal: -32, expInterior: 294880, expEdge: 196576, expCorner: 131040};
      vecs[2] = '{name: "mixed_neg", xVal: 3,    kVal: -2,  bVal: 5,   expInterior: -49,    expEdge: -31,    expCorner: -19};
      vecs[3] = '{name: "neg_pix",  xVal: -1,    kVal: 1,   bVal: 0,   expInterior: -9,     expEdge: -6,     expCorner: -4};

      // Reset held low with live inputs and a running clock.
      randVec(xv, kv, bv);
      bus.in_valid = 1'b1;
      bus.x = xv;
      bus.k = kv;
      bus.b = bv;
      #1 rstn = 1'b0;
      #1 checkOutput("reset_async", 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         randVec(xv, kv, bv);
         applyStimulus(1'b1, xv, kv, bv);
         checkOutput("reset_hold", 1'b0, '0);
      end
      rstn = 1'b1;

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < XN; j++) xv[j] = XB'(vecs[i].xVal);
         for (int j = 0; j < KN; j++) kv[j] = KB'(vecs[i].kVal);
         for (int j = 0; j < BN; j++) bv[j] = KB'(vecs[i].bVal);
         applyStimulus(1'b1, xv, kv, bv);
         checkOutput(string'(vecs[i].name), 1'b1,
                     uniformExpect(vecs[i].expInterior, vecs[i].expEdge, vecs[i].expCorner));
      end

      // Single weight: only output (0,0) channel 3 sees the pixel.
      xv = '0;
      kv = '0;
      bv = '0;
      xv[0] = XB'(5);
      kv[3] = KB'(2);
      bv[3] = KB'(-1);
      ev = '0;
      for (int p = 0; p < 16; p++) ev[p*8+3] = YB'(-1);
      ev[3] = YB'(9);
      applyStimulus(1'b1, xv, kv, bv);
      checkOutput("single_weight", 1'b1, ev);

      // Back-to-back results, then hold with garbage on the inputs.
      randVec(xv, kv, bv);
      randVec(xv2, kv2, bv2);
      ev  = refModel(xv, kv, bv);
      ev2 = refModel(xv2, kv2, bv2);
      applyStimulus(1'b1, xv, kv, bv);
      checkOutput("b2b_first", 1'b1, ev);
      applyStimulus(1'b1, xv2, kv2, bv2);
      checkOutput("b2b_second", 1'b1, ev2);
      randVec(xv, kv, bv);
      applyStimulus(1'b0, xv, kv, bv);
      checkOutput("hold_1", 1'b0, ev2);
      randVec(xv, kv, bv);
      applyStimulus(1'b0, xv, kv, bv);
      checkOutput("hold_2", 1'b0, ev2);

      // Mid-stream reset clears a fresh result without a clock edge.
      randVec(xv, kv, bv);
      applyStimulus(1'b1, xv, kv, bv);
      checkOutput("pre_reset", 1'b1, refModel(xv, kv, bv));
      #2 rstn = 1'b0;
      #1 checkOutput("midreset_async", 1'b0, '0);
      randVec(xv, kv, bv);
      applyStimulus(1'b1, xv, kv, bv);
      checkOutput("midreset_hold", 1'b0, '0);
      rstn = 1'b1;
      randVec(xv, kv, bv);
      applyStimulus(1'b1, xv, kv, bv);
      checkOutput("post_reset_first", 1'b1, refModel(xv, kv, bv));

      for (int i = 0; i < 1000; i++) begin
         randVec(xv, kv, bv);
         applyStimulus(1'b1, xv, kv, bv);
         checkOutput("random", 1'b1, refModel(xv, kv, bv));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
